mean_update: RTL

- Consumer end of the bengine statistics interface; one k-means iteration step.
- On `start`, captures per-cluster channel sums (`accumolator`) and pixel counts (`counters`) from bengine.
- Divides each sum by its count with a serial divider and produces the next `meanOut`/`enabledOut`, which feed back into bengine `meanIn`/`enabled` for the next image pass.
- Also flags convergence.

---
 rtl/mean_pkg.sv | 36 +++
 rtl/mean_div.sv | 66 ++++++
 rtl/mean_update.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mean_pkg.sv
// Shared constants and types for the k-means mean-update block.
// Build option: MEAN_ROUND_EN adds round-half-up before each divide.
package mean_pkg;

    localparam int DEF_T     = 16;
    localparam int DEF_CH_W  = 8;
    localparam int DEF_CNT_W = 13;
    localparam int DEF_ACC_W = 21;

`ifdef MEAN_ROUND_EN
    // The rounding bias can carry one bit past the accumulator width.
    localparam int ROUND_BITS = 1;
`else
    localparam int ROUND_BITS = 0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_WRITE,
        ST_FIN
    } state_e;

    // Channel order inside a cluster word (B in the low byte).
    localparam logic [1:0] CH_B = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_R = 2'd2;

    // Start edge to done pulse: one LOAD cycle, one DIV+WRITE slot per
    // channel, one FIN cycle, then the registered done.
    function automatic int mean_latency(input int t, input int acc_w);
        return 2 + 3 * t * (acc_w + ROUND_BITS + 1);
    endfunction

endpackage

// File: rtl/mean_div.sv
// Serial restoring divider, one quotient bit per cycle, MSB first.
// The load cycle already retires the first bit, so the quotient is ready
// NW cycles after start_i and is held until the next start.
module mean_div #(
    parameter int NW = 21,
    parameter int DW = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [NW-1:0] num_i,
    input  logic [DW-1:0] den_i,
    output logic [NW-1:0] quo_o,
    output logic          valid_o
);

    localparam int CW = $clog2(NW + 1);

    logic [DW-1:0] rem_q, rem_d, src_rem, den_q, src_den;
    logic [NW-1:0] quo_q, quo_d, src_quo;
    logic [CW-1:0] cnt_q;
    logic          act_q;
    logic [DW+1:0] trial;

    // One restoring step on either the fresh operands or the running state.
    always_comb begin
        src_rem = start_i ? '0 : rem_q;
        src_quo = start_i ? num_i : quo_q;
        src_den = start_i ? den_i : den_q;
        trial   = {1'b0, src_rem, src_quo[NW-1]} - {2'b00, src_den};
        if (!trial[DW+1]) begin
            rem_d = trial[DW-1:0];
            quo_d = {src_quo[NW-2:0], 1'b1};
        end else begin
            rem_d = {src_rem[DW-2:0], src_quo[NW-1]};
            quo_d = {src_quo[NW-2:0], 1'b0};
        end
    end

    // Iteration registers; remaining-step counter runs down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            den_q <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
        end else if (start_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            den_q <= den_i;
            cnt_q <= CW'(NW - 1);
            act_q <= 1'b1;
        end else if (act_q && cnt_q != '0) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
        end else if (act_q) begin
            act_q <= 1'b0;
        end
    end

    assign quo_o   = quo_q;
    assign valid_o = act_q && (cnt_q == '0);

endmodule

// File: rtl/mean_update.sv
// One k-means mean-update step: snapshot bengine statistics on start,
// divide every channel sum by its cluster count with one shared serial
// divider, then publish new means, enables and convergence together.
// Build option: MEAN_ROUND_EN selects round-half-up instead of floor.
module mean_update
    import mean_pkg::*;
#(
    parameter int T     = DEF_T,
    parameter int CH_W  = DEF_CH_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int TOL   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [T*3*ACC_W-1:0] accumolator,
    input  logic [T*CNT_W-1:0]   counters,
    input  logic [T*3*CH_W-1:0]  meanIn,
    output logic [T*3*CH_W-1:0]  meanOut,
    output logic [T-1:0]         enabledOut,
    output logic                 busy,
    output logic                 done,
    output logic                 converged
);

    localparam int NCH = 3 * T;
    localparam int KW  = $clog2(NCH);
    localparam int CLW = (T > 1) ? $clog2(T) : 1;
    localparam int NW  = ACC_W + ROUND_BITS;
    localparam logic [CH_W-1:0] TOL_V = CH_W'(TOL);

    state_e                    state_q, state_d;
    logic [NCH-1:0][ACC_W-1:0] sum_q;
    logic [T-1:0][CNT_W-1:0]   cnt_q;
    logic [NCH-1:0][CH_W-1:0]  old_q, new_q;
    logic [T-1:0]              en_q;
    logic                      conv_q, done_q;
    logic [KW-1:0]             k_q, dk;
    logic [CLW-1:0]            cl_q, dcl;
    logic [1:0]                ch_q;
    logic                      last, div_start, div_valid;
    logic [NW-1:0]             div_num, div_quo;
    logic [CNT_W-1:0]          div_den, cur_cnt;
    logic [CH_W-1:0]           q_sat, res, old_v, diff;

    assign last = (k_q == KW'(NCH - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and divider launch; start outside IDLE is simply not seen.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                div_start = 1'b1;
                state_d   = ST_DIV;
            end
            ST_DIV:   if (div_valid) state_d = ST_WRITE;
            ST_WRITE: begin
                if (last) begin
                    state_d = ST_FIN;
                end else begin
                    div_start = 1'b1;
                    state_d   = ST_DIV;
                end
            end
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Divider operands: current channel in LOAD, the following one in WRITE.
    always_comb begin
        dk  = k_q;
        dcl = cl_q;
        if (state_q == ST_WRITE && !last) begin
            dk  = k_q + KW'(1);
            dcl = (ch_q == CH_R) ? cl_q + CLW'(1) : cl_q;
        end
        div_den = cnt_q[dcl];
`ifdef MEAN_ROUND_EN
        div_num = {1'b0, sum_q[dk]} + NW'(cnt_q[dcl] >> 1);
`else
        div_num = sum_q[dk];
`endif
    end

    mean_div #(
        .NW (NW),
        .DW (CNT_W)
    ) u_div (
        .clk     (clk),
        .rst_n   (reset),
        .start_i (div_start),
        .num_i   (div_num),
        .den_i   (div_den),
        .quo_o   (div_quo),
        .valid_o (div_valid)
    );

    // Channel result: saturate, fall back to the old mean for empty clusters.
    always_comb begin
        cur_cnt = cnt_q[cl_q];
        old_v   = old_q[k_q];
        q_sat   = (|div_quo[NW-1:CH_W]) ? '1 : div_quo[CH_W-1:0];
        res     = (cur_cnt == '0) ? old_v : q_sat;
        diff    = (res > old_v) ? res - old_v : old_v - res;
    end

    // Snapshot, per-channel write-back and the single publish in FIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q      <= '0;
            cnt_q      <= '0;
            old_q      <= '0;
            new_q      <= '0;
            en_q       <= '0;
            conv_q     <= 1'b0;
            done_q     <= 1'b0;
            k_q        <= '0;
            cl_q       <= '0;
            ch_q       <= CH_B;
            meanOut    <= '0;
            enabledOut <= '0;
            converged  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (start) begin
                    // Statistics are only valid in the start cycle.
                    sum_q  <= accumolator;
                    cnt_q  <= counters;
                    old_q  <= meanIn;
                    k_q    <= '0;
                    cl_q   <= '0;
                    ch_q   <= CH_B;
                    conv_q <= 1'b1;
                end
                ST_WRITE: begin
                    new_q[k_q]  <= res;
                    en_q[cl_q]  <= (cur_cnt != '0);
                    if (diff > TOL_V) conv_q <= 1'b0;
                    k_q <= k_q + KW'(1);
                    case (ch_q)
                        CH_B:    ch_q <= CH_G;
                        CH_G:    ch_q <= CH_R;
                        default: begin
                            ch_q <= CH_B;
                            cl_q <= cl_q + CLW'(1);
                        end
                    endcase
                end
                ST_FIN: begin
                    meanOut    <= new_q;
                    enabledOut <= en_q;
                    converged  <= conv_q;
                    done_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule
